bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Read-side initiator for a bram_tdp port: on a start command, reads LEN consecutive words
//  from BASE_ADDR, absorbs the BRAM's fixed 1-cycle read latency, and presents the words in
//  order on a valid/ready output stream with full backpressure support.
//  Sits between a bram_tdp port (mem_* pins) and any stream consumer (DMA, debug dump, CPU bus).
// PARAMETERS
//  DATA   72  word width, matches bram_tdp data width
//  ADDR   10  address width; memory depth = 2**ADDR words
//  FDEPTH 4   output FIFO depth in words (power of 2, >= 4)
// PORTS
//  clk        in   1       single clock; bram_tdp port clock is the same clk
//  reset      in   1       asynchronous, active-high; clears all state
//  start      in   1       command pulse; sampled only while busy==0
//  base_addr  in   ADDR    first word address, captured with start
//  len        in   ADDR+1  word count, 0..2**ADDR, captured with start
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse when last word is handed off (or len==0)
//  mem_en     out  1       read-issue strobe to BRAM port
//  mem_wr     out  1       constant 0 (this block never writes)
//  mem_addr   out  ADDR    read address, valid when mem_en==1
//  mem_dout   in   DATA    BRAM read data, valid 1 cycle after mem_en
//  out_valid  out  1       output word available
//  out_data   out  DATA    output word
//  out_ready  in   1       consumer accepts when out_valid & out_ready
//  out_last   out  1       only with BRSR_LAST_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset: busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_last=0; FIFO empty, in-flight=0.
//  Reset asserted mid-transfer aborts it: FIFO flushed, no done pulse, BRAM reads in flight dropped.
//  States: IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE : start=1 captures base_addr/len, busy=1. len==0 -> done=1 next cycle, stay IDLE, no reads.
//          otherwise -> ISSUE.
//   ISSUE: mem_en=1 when (fifo_count + inflight) < FDEPTH-1; mem_addr increments by 1 per issue,
//          wrapping modulo 2**ADDR (base 1020, len 8 reads 1020..1023,0..3). After last issue -> DRAIN.
//   DRAIN: wait until all issued words have been accepted by the consumer; then done=1 for one
//          cycle, busy=0, -> IDLE (done and busy fall on the same edge).
//  inflight is 1 in the cycle after mem_en, else 0; mem_dout is pushed to FIFO that cycle.
//  Credit rule guarantees FIFO never overflows regardless of out_ready.
//  Latency: start accepted at edge 0 -> mem_en cycle 1 -> FIFO push edge 2 -> out_valid cycle 3.
//  Throughput: 1 word/cycle sustained while out_ready=1.
//  out_valid = FIFO non-empty; out_data = FIFO head; stable while out_valid & !out_ready.
//  Simultaneous push and pop: count unchanged, order preserved.
//  start while busy: ignored, no effect on current transfer.
//  Counters: issue count and accept count are ADDR+1 bits so len = 2**ADDR is legal.
// CONFIGURATION
//  BRSR_LAST_EN defined: out_last port exists; high with the final word of a transfer
//   (qualified by out_valid); 0 otherwise. A 1-bit tag is stored alongside each FIFO entry.
//  BRSR_LAST_EN undefined: out_last port absent; FIFO stores DATA bits only; end of transfer
//   visible only through done.
// TESTING
//  1 reset mid-ISSUE with out_ready=0 -> all outputs at reset values next cycle; new start works.
//  2 base=5, len=4, out_ready=1, mem[i]=i -> out_data 5,6,7,8 on cycles 3..6; done in cycle 7.
//  3 base=1022, len=4 -> mem_addr 1022,1023,0,1; data out in that order; out_last on 4th word
//    (BRSR_LAST_EN build).
//  4 len=8, out_ready=0 for 20 cycles then 1 -> exactly FDEPTH-1 reads issued while stalled,
//    no loss/duplication, 8 words in order, done once.
//  5 len=0 -> done 1 cycle after start, mem_en never asserted, out_valid stays 0.
//  6 start pulsed during busy; len=1024, random out_ready -> second start ignored, 1024 words in
//    order, mem_wr always 0.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// Port bundles for bram_stream_reader: BRAM read port and output word stream.
// The stream carries a "last" flag only when BRSR_LAST_EN is defined.
interface bram_rd_if #(
   parameter int DATA = 72,
   parameter int ADDR = 10
);
   logic            en;
   logic            wr;
   logic [ADDR-1:0] addr;
   logic [DATA-1:0] dout;

   modport master (output en, output wr, output addr, input dout);
   modport slave  (input en, input wr, input addr, output dout);
endinterface

interface brsr_stream_if #(
   parameter int DATA = 72
);
   logic            valid;
   logic            ready;
   logic [DATA-1:0] data;
`ifdef BRSR_LAST_EN
   logic            last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
`else
   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
`endif
endinterface

// File: rtl/bram_stream_reader.sv
// Reads len consecutive BRAM words from base_addr and streams them out in order with backpressure.
// Optional feature macro: BRSR_LAST_EN adds a per-word last tag and the stream's last output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; len==0 completes without any reads
// S_ISSUE  | issuing reads while FIFO credit is available
// S_DRAIN  | all reads issued; waiting for consumer to take last word
module bram_stream_reader #(
   parameter int DATA   = 72,
   parameter int ADDR   = 10,
   parameter int FDEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [ADDR-1:0] base_addr_i,
   input  logic [ADDR:0]   len_i,
   output logic            busy_o,
   output logic            done_o,
   bram_rd_if.master       mem,
   brsr_stream_if.master   out_s
);

   localparam int PW = $clog2(FDEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR:0] ONE = (ADDR+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;

   logic [ADDR-1:0] addr_q, addr_d;
   logic [ADDR:0]   len_q, len_d;
   logic [ADDR:0]   issue_cnt_q, issue_cnt_d;
   logic [ADDR:0]   accept_cnt_q, accept_cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            inflight_q;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DATA-1:0] fifo_mem [FDEPTH];

   logic            start_ok;
   logic            issue;
   logic            push;
   logic            pop;
   logic            last_issue;
   logic            last_accept;
   logic [CW-1:0]   credit_used;

`ifdef BRSR_LAST_EN
   logic            inflight_last_q;
   logic            tag_mem [FDEPTH];
`endif

   assign start_ok    = start_i & ~busy_q;
   assign credit_used = count_q + CW'(inflight_q);
   assign push        = inflight_q;
   assign pop         = (count_q != '0) & out_s.ready;
   assign last_issue  = issue & (issue_cnt_q == len_q - ONE);
   assign last_accept = pop & (state_q == S_DRAIN) & (accept_cnt_q == len_q - ONE);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok && (len_i != '0)) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (last_issue) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (last_accept) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // One slot is held back for the read that is still in the BRAM pipeline.
   always_comb begin
      issue = 1'b0;
      if ((state_q == S_ISSUE) && (credit_used < CW'(FDEPTH - 1))) begin
         issue = 1'b1;
      end
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      addr_d       = addr_q;
      len_d        = len_q;
      issue_cnt_d  = issue_cnt_q;
      accept_cnt_d = accept_cnt_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      if (start_ok) begin
         addr_d       = base_addr_i;
         len_d        = len_i;
         issue_cnt_d  = '0;
         accept_cnt_d = '0;
         busy_d       = 1'b1;
         done_d       = (len_i == '0);
      end else begin
         if (done_q) begin
            busy_d = 1'b0;
         end
         if (issue) begin
            addr_d      = addr_q + ADDR'(1);
            issue_cnt_d = issue_cnt_q + ONE;
         end
         if (pop) begin
            accept_cnt_d = accept_cnt_q + ONE;
         end
         if (last_accept) begin
            done_d = 1'b1;
         end
      end

      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q       <= '0;
         len_q        <= '0;
         issue_cnt_q  <= '0;
         accept_cnt_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         inflight_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         addr_q       <= addr_d;
         len_q        <= len_d;
         issue_cnt_q  <= issue_cnt_d;
         accept_cnt_q <= accept_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         inflight_q   <= issue;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

`ifdef BRSR_LAST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_last_q <= 1'b0;
      end else begin
         inflight_last_q <= last_issue;
      end
   end
`endif

   // FIFO storage needs no reset: entries are only visible behind count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem.dout;
`ifdef BRSR_LAST_EN
         tag_mem[wr_ptr_q]  <= inflight_last_q;
`endif
      end
   end

   // ---------------- outputs ----------------
   assign mem.en     = issue;
   assign mem.wr     = 1'b0;
   assign mem.addr   = addr_q;

   assign out_s.valid = (count_q != '0);
   assign out_s.data  = fifo_mem[rd_ptr_q];
`ifdef BRSR_LAST_EN
   assign out_s.last  = (count_q != '0) & tag_mem[rd_ptr_q];
`endif

   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle-latency BRAM.
module tb_bram_stream_reader;

   localparam int DATA = 72;
   localparam int ADDR = 10;
   localparam int DEPTH = 1 << ADDR;

   logic            clk;
   logic            reset;
   logic            start;
   logic [ADDR-1:0] base_addr;
   logic [ADDR:0]   len;
   logic            busy;
   logic            done;

   bram_rd_if     #(.DATA(DATA), .ADDR(ADDR)) rd ();
   brsr_stream_if #(.DATA(DATA))              st ();

   bram_stream_reader #(.DATA(DATA), .ADDR(ADDR), .FDEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start),
      .base_addr_i (base_addr),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .mem         (rd),
      .out_s       (st)
   );

   logic [DATA-1:0] mem_arr [DEPTH];

   always @(posedge clk) begin
      if (rd.en) rd.dout <= mem_arr[rd.addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_words, n_bad, n_done, n_en, n_wr, n_last_bad, timed_out;

   function automatic logic [DATA-1:0] word_of(input int a);
      logic [DATA-1:0] v;
      v = DATA'(unsigned'(a));
      return (v << 44) ^ v ^ {8'hC3, 64'h0};
   endfunction

   task automatic chkd(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Leaves the bench at the negedge of cycle 1 (first cycle after the accepting edge).
   task automatic do_start(input int b, input int l);
      base_addr = ADDR'(b);
      len       = (ADDR+1)'(l);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic collect(input int b, input int l, input bit rnd, input bit restart, input int budget);
      int cyc = 0;
      bit fin = 1'b0;
      n_words = 0; n_bad = 0; n_done = 0; n_last_bad = 0;
      while (!fin && cyc < budget) begin
         st.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start    = restart && (cyc == 4);
         if (restart && cyc == 4) begin
            base_addr = ADDR'(500);
            len       = (ADDR+1)'(3);
         end
         if (rd.wr !== 1'b0) n_wr++;
         if (rd.en === 1'b1) n_en++;
         if (done === 1'b1) begin
            n_done++;
            fin = 1'b1;
         end
         if (st.valid === 1'b1 && st.ready) begin
            if (st.data !== word_of((b + n_words) % DEPTH)) n_bad++;
`ifdef BRSR_LAST_EN
            if (st.last !== (n_words == l - 1)) n_last_bad++;
`endif
            n_words++;
         end
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      timed_out = fin ? 0 : 1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] = word_of(i);
      reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; st.ready = 1'b0; n_wr = 0;
      repeat (2) @(negedge clk);
      chki("rst_busy",  32'(busy),     0);
      chki("rst_done",  32'(done),     0);
      chki("rst_en",    32'(rd.en),    0);
      chki("rst_addr",  32'(rd.addr),  0);
      chki("rst_valid", 32'(st.valid), 0);
`ifdef BRSR_LAST_EN
      chki("rst_last",  32'(st.last),  0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // 1: reset mid-ISSUE with the consumer stalled
      do_start(100, 8);
      @(negedge clk);
      chki("t1_en_before_rst", 32'(rd.en), 1);
      reset = 1'b1;
      #1;
      chki("t1_busy",  32'(busy),     0);
      chki("t1_done",  32'(done),     0);
      chki("t1_en",    32'(rd.en),    0);
      chki("t1_addr",  32'(rd.addr),  0);
      chki("t1_valid", 32'(st.valid), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chki("t1_valid_after", 32'(st.valid), 0);
      chki("t1_busy_after",  32'(busy),     0);

      // 2: base 5, len 4, consumer always ready
      st.ready = 1'b1;
      do_start(5, 4);
      chki("t2_c1_en",    32'(rd.en),    1);
      chki("t2_c1_addr",  32'(rd.addr),  5);
      chki("t2_c1_busy",  32'(busy),     1);
      chki("t2_c1_valid", 32'(st.valid), 0);
      @(negedge clk);
      chki("t2_c2_addr",  32'(rd.addr),  6);
      chki("t2_c2_valid", 32'(st.valid), 0);
      @(negedge clk);
      chki("t2_c3_valid", 32'(st.valid), 1);
      chkd("t2_c3_data",  st.data, word_of(5));
      @(negedge clk);
      chkd("t2_c4_data",  st.data, word_of(6));
      @(negedge clk);
      chkd("t2_c5_data",  st.data, word_of(7));
      chki("t2_c5_en",    32'(rd.en), 0);
      @(negedge clk);
      chkd("t2_c6_data",  st.data, word_of(8));
      chki("t2_c6_done",  32'(done), 0);
      @(negedge clk);
      chki("t2_c7_done",  32'(done),     1);
      chki("t2_c7_busy",  32'(busy),     1);
      chki("t2_c7_valid", 32'(st.valid), 0);
      @(negedge clk);
      chki("t2_c8_done",  32'(done), 0);
      chki("t2_c8_busy",  32'(busy), 0);

      // 3: address wrap at the top of memory
      do_start(1022, 4);
      chki("t3_c1_addr", 32'(rd.addr), 1022);
      @(negedge clk);
      chki("t3_c2_addr", 32'(rd.addr), 1023);
      @(negedge clk);
      chki("t3_c3_addr", 32'(rd.addr), 0);
      chkd("t3_c3_data", st.data, word_of(1022));
`ifdef BRSR_LAST_EN
      chki("t3_c3_last", 32'(st.last), 0);
`endif
      @(negedge clk);
      chki("t3_c4_addr", 32'(rd.addr), 1);
      chki("t3_c4_en",   32'(rd.en),   1);
      chkd("t3_c4_data", st.data, word_of(1023));
      @(negedge clk);
      chkd("t3_c5_data", st.data, word_of(0));
      @(negedge clk);
      chkd("t3_c6_data", st.data, word_of(1));
`ifdef BRSR_LAST_EN
      chki("t3_c6_last", 32'(st.last), 1);
`endif
      @(negedge clk);
      chki("t3_c7_done", 32'(done), 1);
      @(negedge clk);

      // 5: zero-length transfer
      do_start(7, 0);
      chki("t5_c1_done",  32'(done),     1);
      chki("t5_c1_en",    32'(rd.en),    0);
      chki("t5_c1_valid", 32'(st.valid), 0);
      @(negedge clk);
      chki("t5_c2_done",  32'(done),     0);
      chki("t5_c2_busy",  32'(busy),     0);
      chki("t5_c2_en",    32'(rd.en),    0);
      chki("t5_c2_valid", 32'(st.valid), 0);

      // 4: 20-cycle stall; FDEPTH-1 reads may be issued
      st.ready = 1'b0;
      n_en = 0;
      do_start(40, 8);
      for (int i = 0; i < 20; i++) begin
         if (rd.en === 1'b1) n_en++;
         @(negedge clk);
      end
      chki("t4_stall_reads", 32'(n_en), 3);
      chki("t4_stall_valid", 32'(st.valid), 1);
      chkd("t4_stall_head",  st.data, word_of(40));
      collect(40, 8, 1'b0, 1'b0, 200);
      chki("t4_timeout", 32'(timed_out), 0);
      chki("t4_words",   32'(n_words),   8);
      chki("t4_order",   32'(n_bad),     0);
      chki("t4_done",    32'(n_done),    1);
      chki("t4_reads",   32'(n_en),      8);

      // 6: full-depth transfer, random backpressure, start pulsed while busy
      n_en = 0;
      do_start(300, 1024);
      collect(300, 1024, 1'b1, 1'b1, 8000);
      chki("t6_timeout", 32'(timed_out), 0);
      chki("t6_words",   32'(n_words),   1024);
      chki("t6_order",   32'(n_bad),     0);
      chki("t6_done",    32'(n_done),    1);
      chki("t6_reads",   32'(n_en),      1024);
`ifdef BRSR_LAST_EN
      chki("t6_last",    32'(n_last_bad), 0);
`endif
      chki("t6_busy_end",  32'(busy),     0);
      chki("t6_valid_end", 32'(st.valid), 0);
      chki("mem_wr_never", 32'(n_wr),     0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
